// File: rtl/huffman_stream_ctrl_if.sv
// Stream bundle for the Huffman controller: symbol input and packed-byte output.
// master = the environment (symbol source / byte sink), slave = the controller.
interface huffman_stream_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_ascii;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_valid, in_ascii, out_ready,
        input  in_ready, out_byte, out_valid, out_last
    );

    modport slave (
        input  in_valid, in_ascii, out_ready,
        output in_ready, out_byte, out_valid, out_last
    );
endinterface

// File: rtl/huffman_stream_ctrl.sv
// Huffman stream controller: takes ASCII symbols, looks each one up in an
// external combinational code table, serialises the code MSB-first into a
// byte accumulator and emits packed bytes. Flush pads the last partial byte.
module huffman_stream_ctrl #(
    parameter int CODE_W = 10,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    huffman_stream_ctrl_if.slave  bus,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [6:0]            tbl_ascii,
    input  logic [CODE_W-1:0]     tbl_code,
    input  logic [LEN_W-1:0]      tbl_len,
    output logic                  busy,
    output logic [CNT_W-1:0]      bit_count,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        SHIFT      = 3'd2,
        EMIT       = 3'd3,
        FLUSH_EMIT = 3'd4
    } state_t;

    state_t            state_reg;
    logic [6:0]        tbl_ascii_reg;
    logic [CODE_W-1:0] code_reg;
    logic [LEN_W-1:0]  rem_reg;
    logic [7:0]        acc_reg;
    logic [3:0]        acc_cnt_reg;
    logic [CNT_W-1:0]  bit_count_reg;
    logic [7:0]        out_byte_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              in_ready_reg;
    logic              busy_reg;
    logic              flush_done_reg;
    logic              err_reg;

    logic [LEN_W-1:0]  rem_next;
    logic [CODE_W-1:0] code_shifted;
    logic [7:0]        acc_next;
    logic [3:0]        acc_cnt_next;
    logic [7:0]        flush_byte;
    logic              len_bad;

    // Datapath helpers: next code bit, shifted accumulator, padded flush byte
    always_comb begin
        rem_next     = rem_reg - LEN_W'(1);
        code_shifted = code_reg >> rem_next;
        acc_next     = {acc_reg[6:0], code_shifted[0]};
        acc_cnt_next = acc_cnt_reg + 4'd1;
        // valid bits sit in the low acc_cnt positions; move them up to bit 7
        flush_byte   = acc_reg << (4'd8 - acc_cnt_reg);
        len_bad      = (tbl_len == '0) || (int'(tbl_len) > CODE_W);
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            tbl_ascii_reg  <= '0;
            code_reg       <= '0;
            rem_reg        <= '0;
            acc_reg        <= '0;
            acc_cnt_reg    <= '0;
            bit_count_reg  <= '0;
            out_byte_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            in_ready_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            flush_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            flush_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // a symbol wins over a simultaneous flush request
                    if (bus.in_valid) begin
                        tbl_ascii_reg <= bus.in_ascii;
                        state_reg     <= LOOKUP;
                        in_ready_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                    end else if (flush && (acc_cnt_reg != 4'd0)) begin
                        out_byte_reg  <= flush_byte;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b1;
                        state_reg     <= FLUSH_EMIT;
                        in_ready_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                    end else if (flush) begin
                        flush_done_reg <= 1'b1;
                    end
                end

                LOOKUP: begin
                    code_reg <= tbl_code;
                    rem_reg  <= tbl_len;
                    if (len_bad) begin
                        err_reg      <= 1'b1;
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        state_reg <= SHIFT;
                    end
                end

                SHIFT: begin
                    acc_reg       <= acc_next;
                    rem_reg       <= rem_next;
                    bit_count_reg <= bit_count_reg + CNT_W'(1);
                    if (acc_cnt_next == 4'd8) begin
                        out_byte_reg  <= acc_next;
                        out_valid_reg <= 1'b1;
                        acc_cnt_reg   <= 4'd0;
                        state_reg     <= EMIT;
                    end else begin
                        acc_cnt_reg <= acc_cnt_next;
                        if (rem_next == '0) begin
                            state_reg    <= IDLE;
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                        end
                    end
                end

                EMIT: begin
                    // byte is held until the sink takes it; remaining code bits wait
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (rem_reg != '0) begin
                            state_reg <= SHIFT;
                        end else begin
                            state_reg    <= IDLE;
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                        end
                    end
                end

                FLUSH_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_reg  <= 1'b0;
                        out_last_reg   <= 1'b0;
                        acc_reg        <= '0;
                        acc_cnt_reg    <= '0;
                        flush_done_reg <= 1'b1;
                        state_reg      <= IDLE;
                        in_ready_reg   <= 1'b1;
                        busy_reg       <= 1'b0;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_byte  = out_byte_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign tbl_ascii     = tbl_ascii_reg;
    assign busy          = busy_reg;
    assign bit_count     = bit_count_reg;
    assign flush_done    = flush_done_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Directed bench for huffman_stream_ctrl with a small fixed code table.
module tb_huffman_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        flush_done;
    logic [6:0]  tbl_ascii;
    logic [9:0]  tbl_code;
    logic [3:0]  tbl_len;
    logic        busy;
    logic [15:0] bit_count;
    logic        err;

    logic        force_en;
    logic [3:0]  force_len;

    int          n_checks;
    int          n_fails;
    int          fd_count;
    logic [8:0]  byte_q[$];

    huffman_stream_ctrl_if bus ();

    huffman_stream_ctrl #(.CODE_W(10), .LEN_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .tbl_ascii  (tbl_ascii),
        .tbl_code   (tbl_code),
        .tbl_len    (tbl_len),
        .busy       (busy),
        .bit_count  (bit_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Code table: e=010, t=1101, a=1011, space=111, z=110000010, x=1100001
    always_comb begin
        tbl_code = '0;
        tbl_len  = '0;
        case (tbl_ascii)
            7'd101: begin tbl_code = 10'b0000000010; tbl_len = 4'd3; end
            7'd116: begin tbl_code = 10'b0000001101; tbl_len = 4'd4; end
            7'd97:  begin tbl_code = 10'b0000001011; tbl_len = 4'd4; end
            7'd32:  begin tbl_code = 10'b0000000111; tbl_len = 4'd3; end
            7'd122: begin tbl_code = 10'b0110000010; tbl_len = 4'd9; end
            7'd120: begin tbl_code = 10'b0001100001; tbl_len = 4'd7; end
            default: begin tbl_code = '0; tbl_len = '0; end
        endcase
        if (force_en) tbl_len = force_len;
    end

    // Byte and flush_done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            byte_q.push_back({bus.out_last, bus.out_byte});
            $display("byte 0x%02h last=%0b bit_count=%0d", bus.out_byte, bus.out_last, bit_count);
        end
        if (!rst && flush_done) fd_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ascii = '0;
        flush        = 1'b0;
        force_en     = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        byte_q.delete();
        fd_count = 0;
    endtask

    task automatic send_sym(input logic [6:0] ch);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_ascii = ch;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_flush();
        int t = 0;
        int fd0;
        wait_idle();
        fd0 = fd_count;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        while (fd_count == fd0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("flush_done_pulses", fd_count - fd0, 32'd1);
    endtask

    task automatic expect_bytes(input int n, input logic [8:0] e0, input logic [8:0] e1);
        check("byte_count", byte_q.size(), n);
        if (n > 0 && byte_q.size() > 0) check("byte0", {23'd0, byte_q[0]}, {23'd0, e0});
        if (n > 1 && byte_q.size() > 1) check("byte1", {23'd0, byte_q[1]}, {23'd0, e1});
        byte_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        fd_count      = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        force_en      = 1'b0;
        force_len     = '0;
        bus.in_valid  = 1'b0;
        bus.in_ascii  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Test 1: reset state, then "eta" + flush
        do_reset();
        @(negedge clk);
        check("rst_in_ready",   {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_last",   {31'd0, bus.out_last},  32'd0);
        check("rst_out_byte",   {24'd0, bus.out_byte},  32'd0);
        check("rst_busy",       {31'd0, busy},          32'd0);
        check("rst_err",        {31'd0, err},           32'd0);
        check("rst_flush_done", {31'd0, flush_done},    32'd0);
        check("rst_bit_count",  {16'd0, bit_count},     32'd0);
        check("rst_tbl_ascii",  {25'd0, tbl_ascii},     32'd0);
        send_sym(7'd101);
        send_sym(7'd116);
        send_sym(7'd97);
        wait_idle();
        expect_bytes(1, 9'h05B, 9'h000);
        do_flush();
        expect_bytes(1, 9'h160, 9'h000);
        check("t1_bit_count", {16'd0, bit_count}, 32'd11);

        // Test 2: three spaces + flush
        do_reset();
        send_sym(7'd32);
        send_sym(7'd32);
        send_sym(7'd32);
        do_flush();
        expect_bytes(2, 9'h0FF, 9'h180);
        check("t2_bit_count", {16'd0, bit_count}, 32'd9);

        // Test 3: 'z' with back-pressure during EMIT
        do_reset();
        bus.out_ready = 1'b0;
        send_sym(7'd122);
        begin
            int t = 0;
            @(negedge clk);
            while (!bus.out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("t3_hold_byte",     {24'd0, bus.out_byte},  32'hC1);
            check("t3_hold_in_ready", {31'd0, bus.in_ready},  32'd0);
            @(negedge clk);
        end
        check("t3_bits_held", {16'd0, bit_count}, 32'd8);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();
        check("t3_bit_count", {16'd0, bit_count}, 32'd9);
        do_flush();
        expect_bytes(2, 9'h0C1, 9'h100);

        // Test 4: illegal lengths set sticky err
        do_reset();
        force_en  = 1'b1;
        force_len = 4'd0;
        send_sym(7'd101);
        @(negedge clk);
        check("t4_lookup_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("t4_back_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t4_err_len0",      {31'd0, err},          32'd1);
        force_len = 4'd11;
        send_sym(7'd101);
        @(negedge clk);
        @(negedge clk);
        check("t4_back_in_ready2", {31'd0, bus.in_ready}, 32'd1);
        check("t4_err_len11",      {31'd0, err},          32'd1);
        check("t4_bit_count",      {16'd0, bit_count},    32'd0);
        force_en = 1'b0;
        send_sym(7'd101);
        wait_idle();
        check("t4_err_sticky",  {31'd0, err},       32'd1);
        check("t4_bit_count_e", {16'd0, bit_count}, 32'd3);
        expect_bytes(0, 9'h000, 9'h000);

        // Test 5: empty flush, then flush together with a symbol
        do_reset();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("t5_empty_flush_done", {31'd0, flush_done},    32'd1);
        check("t5_empty_no_valid",   {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("t5_flush_done_pulse", {31'd0, flush_done},    32'd0);
        bus.in_valid = 1'b1;
        bus.in_ascii = 7'd101;
        flush        = 1'b1;
        @(posedge clk);
        #1 begin
            bus.in_valid = 1'b0;
            flush        = 1'b0;
        end
        @(negedge clk);
        check("t5_sym_first_busy", {31'd0, busy},       32'd1);
        check("t5_sym_first_tbl",  {25'd0, tbl_ascii},  32'd101);
        check("t5_no_flush_done",  {31'd0, flush_done}, 32'd0);
        wait_idle();
        check("t5_bit_count", {16'd0, bit_count}, 32'd3);
        expect_bytes(0, 9'h000, 9'h000);
        do_flush();
        expect_bytes(1, 9'h140, 9'h000);

        // Test 6: reset in the middle of shifting 'x'
        do_reset();
        send_sym(7'd120);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t6_pre_busy",      {31'd0, busy},      32'd1);
        check("t6_pre_bit_count", {16'd0, bit_count}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_in_ready",   {31'd0, bus.in_ready},  32'd1);
        check("t6_busy",       {31'd0, busy},          32'd0);
        check("t6_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("t6_out_byte",   {24'd0, bus.out_byte},  32'd0);
        check("t6_bit_count",  {16'd0, bit_count},     32'd0);
        check("t6_tbl_ascii",  {25'd0, tbl_ascii},     32'd0);
        check("t6_err",        {31'd0, err},           32'd0);
        byte_q.delete();
        fd_count = 0;
        send_sym(7'd101);
        do_flush();
        expect_bytes(1, 9'h140, 9'h000);
        check("t6_bit_count_e", {16'd0, bit_count}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
